// File: rtl/writeback_pipe.sv
// writeback_pipe: RV32I writeback stage with load extraction, x0 write suppression, one-entry skid buffer and instret counter.
module writeback_pipe #(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 64,
    parameter bit RETIRE_ALL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  result_i,
    input  logic [XLEN-1:0]  memdata_i,
    input  logic             wb_ready_i,
    output logic             out_valid_o,
    output logic             rdvalid_o,
    output logic [4:0]       rdnum_o,
    output logic [XLEN-1:0]  rddata_o,
    output logic [XLEN-1:0]  retire_pc_o,
    output logic [CNT_W-1:0] instret_o
);
    typedef struct packed {
        logic            rdv;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } ent_t;
    ent_t             out_q, out_d, skid_q, skid_d, in_e;
    logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [XLEN-1:0]  ld_data;
    logic             writes_rd, is_load, accept, retire, out_free;
    logic             unused_inst;
    assign unused_inst = ^inst_i[31:15];
    always_comb begin
        opc       = inst_i[6:0];
        f3        = inst_i[14:12];
        is_load   = opc == 7'b0000011;
        writes_rd = opc == 7'b0110011 || opc == 7'b0010011 || opc == 7'b1100111 || is_load ||
                    opc == 7'b0110111 || opc == 7'b0010111 || opc == 7'b1101111;
        byte_v    = 8'(memdata_i >> {result_i[1:0], 3'b000});
        half_v    = result_i[1] ? memdata_i[31:16] : memdata_i[15:0];
        case (f3)
            3'b000:  ld_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, byte_v};
            3'b001:  ld_data = {{(XLEN-16){half_v[15]}}, half_v};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, half_v};
            default: ld_data = memdata_i;
        endcase
        in_e.rdv  = writes_rd & (inst_i[11:7] != 5'd0);
        in_e.rd   = inst_i[11:7];
        in_e.data = is_load ? ld_data : result_i;
        in_e.pc   = pc_i;
    end
    // The skid only fills while the output is stalled, so ready_o=0 guarantees
    // no accept can coincide with a skid-to-output move.
    always_comb begin
        accept       = valid_i & ready_q;
        retire       = out_valid_q & wb_ready_i;
        out_free     = ~out_valid_q | retire;
        out_valid_d  = out_free ? (skid_valid_q | accept) : out_valid_q;
        out_d        = out_free ? (skid_valid_q ? skid_q : accept ? in_e : out_q) : out_q;
        skid_valid_d = out_free ? 1'b0 : (skid_valid_q | accept);
        skid_d       = (~out_free & accept) ? in_e : skid_q;
        ready_d      = ~skid_valid_d;
        instret_d    = instret_q + CNT_W'(retire & (RETIRE_ALL | out_q.rdv));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            instret_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            instret_q    <= instret_d;
        end
    end
    always_ff @(posedge clk) begin
        out_q  <= out_d;
        skid_q <= skid_d;
    end
    assign ready_o     = ready_q;
    assign out_valid_o = out_valid_q;
    assign rdvalid_o   = out_valid_q & out_q.rdv;
    assign rdnum_o     = out_q.rd;
    assign rddata_o    = out_q.data;
    assign retire_pc_o = out_q.pc;
    assign instret_o   = instret_q;
endmodule

// File: tb/tb_writeback_pipe.sv
// tb_writeback_pipe: scoreboard bench for writeback_pipe against a behavioural RV32I writeback model.
module tb_writeback_pipe;
    logic        clk = 0, rst = 0, valid_i = 0, wb_ready_i = 0;
    logic [31:0] pc_i = 0, inst_i = 0, result_i = 0, memdata_i = 0;
    logic        ready_o, out_valid_o, rdvalid_o, ready1, out_valid1, rdvalid1;
    logic [4:0]  rdnum_o, rdnum1;
    logic [31:0] rddata_o, retire_pc_o, rddata1, retire_pc1;
    logic [63:0] instret_o;
    logic [3:0]  instret1;
    typedef struct {logic rdv; logic [4:0] rd; logic [31:0] data; logic [31:0] pc;} exp_t;
    exp_t        sbq[$];
    int          n_checks = 0, n_fail = 0, mode = 0;
    logic [63:0] cnt0 = 0;
    logic [3:0]  cnt1 = 0;
    always #5 clk = ~clk;
    writeback_pipe u0 (.clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i), .inst_i(inst_i),
        .result_i(result_i), .memdata_i(memdata_i), .wb_ready_i(wb_ready_i), .out_valid_o(out_valid_o),
        .rdvalid_o(rdvalid_o), .rdnum_o(rdnum_o), .rddata_o(rddata_o), .retire_pc_o(retire_pc_o), .instret_o(instret_o));
    writeback_pipe #(.CNT_W(4), .RETIRE_ALL(1'b0)) u1 (.clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready1),
        .pc_i(pc_i), .inst_i(inst_i), .result_i(result_i), .memdata_i(memdata_i), .wb_ready_i(wb_ready_i),
        .out_valid_o(out_valid1), .rdvalid_o(rdvalid1), .rdnum_o(rdnum1), .rddata_o(rddata1),
        .retire_pc_o(retire_pc1), .instret_o(instret1));
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic exp_t model(logic [31:0] inst, logic [31:0] res, logic [31:0] mem, logic [31:0] pc);
        exp_t       e;
        logic [7:0] b[4];
        logic [6:0] opc = inst[6:0];
        int         off = int'(res[1:0]);
        for (int i = 0; i < 4; i++) b[i] = mem[8*i +: 8];
        e.rd   = inst[11:7];
        e.pc   = pc;
        e.rdv  = (opc inside {7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111})
                 && e.rd != 0;
        e.data = res;
        if (opc == 7'b0000011)
            case (inst[14:12])
                3'b000:  e.data = 32'($signed(b[off]));
                3'b100:  e.data = 32'(b[off]);
                3'b001:  e.data = 32'($signed({b[(off & 2) + 1], b[off & 2]}));
                3'b101:  e.data = 32'({b[(off & 2) + 1], b[off & 2]});
                default: e.data = mem;
            endcase
        return e;
    endfunction
    task automatic issue(logic [31:0] inst, logic [31:0] res, logic [31:0] mem, logic [31:0] pc);
        int n = 0;
        @(negedge clk);
        inst_i = inst; result_i = res; memdata_i = mem; pc_i = pc; valid_i = 1;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk("accept_timeout", 0, 1);
        else sbq.push_back(model(inst, res, mem, pc));
        @(posedge clk);
        #1 valid_i = 0;
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1; valid_i = 1; inst_i = 32'h0050_0293; pc_i = $urandom;
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_rdvalid", rdvalid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_instret", instret_o, 0);
        @(posedge clk);
        #1 rst = 0; valid_i = 0;
    endtask
    initial forever begin
        @(posedge clk);
        #2 wb_ready_i = mode == 0 ? 1'($urandom_range(0, 1)) : mode == 2;
    end
    initial begin
        exp_t        e;
        logic [4:0]  s_rd;
        logic [31:0] s_data, s_pc;
        bit          have_idle = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sbq.delete(); cnt0 = 0; cnt1 = 0; have_idle = 0;
                continue;
            end
            chk("instret", instret_o, cnt0);
            chk("instret_w4", 64'(instret1), 64'(cnt1));
            if (!out_valid_o) begin
                chk("rdvalid_idle", rdvalid_o, 0);
                if (have_idle) begin
                    chk("idle_rdnum", rdnum_o, s_rd);
                    chk("idle_rddata", rddata_o, s_data);
                    chk("idle_pc", retire_pc_o, s_pc);
                end
                s_rd = rdnum_o; s_data = rddata_o; s_pc = retire_pc_o; have_idle = 1;
            end else have_idle = 0;
            if (out_valid_o && wb_ready_i) begin
                if (sbq.size() == 0) chk("retire_unexpected", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("rdvalid", rdvalid_o, e.rdv);
                    chk("rdvalid_w4", rdvalid1, e.rdv);
                    chk("retire_pc", retire_pc_o, e.pc);
                    if (e.rdv) begin
                        chk("rdnum", rdnum_o, e.rd);
                        chk("rddata", rddata_o, e.data);
                    end
                    cnt0++;
                    if (e.rdv) cnt1++;
                end
            end
        end
    end
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [6:0]  ops[9] = '{7'b0110011, 7'b0010011, 7'b1100111, 7'b0000011, 7'b0110111,
                                7'b0010111, 7'b1101111, 7'b0100011, 7'b1100011};
        logic [31:0] inst, res, mem;
        logic [63:0] s0;
        logic [3:0]  s1;
        int          n;
        do_reset();
        mode = 2;
        issue(32'h0000_0293, 32'h0000_1234, $urandom, 32'h100);
        @(negedge clk);
        chk("latency_valid", out_valid_o, 1);
        chk("addi_rdnum", rdnum_o, 5);
        chk("addi_rddata", rddata_o, 32'h1234);
        issue(32'h0000_0383, 32'h0000_1003, 32'h80FF_0000, 32'h104);
        issue(32'h0000_4383, 32'h0000_1003, 32'h80FF_0000, 32'h108);
        issue(32'h0000_1383, 32'h0000_1002, 32'h80FF_0000, 32'h10C);
        repeat (3) @(negedge clk);
        s0 = cnt0; s1 = cnt1;
        issue(32'h0051_2423, 32'h0000_2000, $urandom, 32'h110);
        issue(32'h0010_0013, 32'h0000_0001, $urandom, 32'h114);
        repeat (3) @(negedge clk);
        chk("retire_all_count", instret_o, s0 + 2);
        chk("retire_wr_count", 64'(instret1), 64'(s1));
        mode = 1;
        issue(32'h0000_0093, 32'hA, $urandom, 32'h200);
        issue(32'h0000_0113, 32'hB, $urandom, 32'h204);
        fork
            issue(32'h0000_0193, 32'hC, $urandom, 32'h208);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_ready_low", ready_o, 0);
                end
                mode = 2;
            end
        join
        repeat (4) @(negedge clk);
        chk("bp_drained", sbq.size(), 0);
        mode = 1;
        issue(32'h0000_0093, 32'h1, $urandom, 32'h300);
        issue(32'h0000_0113, 32'h2, $urandom, 32'h304);
        @(negedge clk);
        chk("skid_full", ready_o, 0);
        do_reset();
        mode = 2;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_idle", out_valid_o, 0);
        end
        mode = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            inst = $urandom;
            inst[6:0] = ops[$urandom_range(0, 8)];
            res = $urandom; mem = $urandom;
            issue(inst, res, mem, $urandom);
        end
        mode = 2;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("final_drain", sbq.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/writeback_pipe.md
Name: writeback_pipe

Overview:
- Registered, parametrised writeback stage for the RV32I pipeline.
- Sits between the memory stage and the register-file write port.
- Does load-data extraction and sign extension, suppresses writes to x0, and adds valid/ready back-pressure from the write port through a one-entry skid buffer.
- Keeps a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width for pc, result and register data; only 32 is supported for load extraction.
- CNT_W, 64, width of the retired-instruction counter.
- RETIRE_ALL, 1, 1: count every accepted instruction; 0: count only instructions that write rd.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- valid_i  in  1  upstream instruction valid
- ready_o  out  1  stage can accept; registered
- pc_i  in  XLEN  instruction pc
- inst_i  in  32  instruction word
- result_i  in  XLEN  ALU result / load address
- memdata_i  in  XLEN  word-aligned load data
- wb_ready_i  in  1  register-file port grants the write this cycle
- out_valid_o  out  1  output register holds an instruction
- rdvalid_o  out  1  register write request
- rdnum_o  out  5  destination register
- rddata_o  out  XLEN  write data
- retire_pc_o  out  XLEN  pc of the held instruction
- instret_o  out  CNT_W  retired count

Behaviour:
- Reset values (synchronous, active-high, clk rising edge): out_valid_o=0, skid empty, ready_o=1, instret_o=0. rdvalid_o=0 follows from out_valid_o=0. Data registers are don't-care, but rdnum_o/rddata_o/retire_pc_o must be stable while out_valid_o=0.
- Reset mid-operation discards both the output entry and the skid entry.

Handshake:
- Input accept = valid_i & ready_o.
- Output retire = out_valid_o & wb_ready_i.
- Latency: an accepted instruction appears on the outputs the next cycle when the output register is empty or retiring.

Output register and skid:
- If the output register is full and not retiring, the accepted instruction goes to the skid.
- ready_o = ~skid_full, registered.
- When the output retires and the skid is full, the skid moves to the output and the skid empties.
- Simultaneous accept and retire with the skid empty: the new entry replaces the output and out_valid_o stays 1.
- Program order is strictly preserved; there is never loss or duplication.

Write decode (at capture):
- writes_rd = opcode in {OP 0110011, OP-IMM 0010011, JALR 1100111, LOAD 0000011, LUI 0110111, AUIPC 0010111, JAL 1101111}.
- rdvalid_o = out_valid_o & writes_rd & (rd != 0).
- The x0 case retires but never requests a write.
- rdvalid_o is held until retire; the write commits only when wb_ready_i=1.

Load extraction (opcode LOAD, from funct3 and off=result_i[1:0]):
- LB (000): sign-extend byte[off].
- LBU (100): zero-extend byte[off].
- LH (001): sign-extend half[off[1]].
- LHU (101): zero-extend half[off[1]].
- LW (010): memdata_i, offset ignored.
- Other funct3: memdata_i.
- Non-load instructions: rddata = result_i.

Counter:
- instret_o increments by 1 on each retire, gated per RETIRE_ALL.
- Wraps modulo 2^CNT_W without saturation.
- Updates the cycle after retire.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_i=1 -> out_valid_o=0, rdvalid_o=0, instret_o=0, ready_o=1.
- ADDI x5 with result 0x0000_1234, wb_ready_i=1 -> next cycle rdvalid_o=1, rdnum_o=5, rddata_o=0x1234; instret_o=1 one cycle later.
- LB, address 0x...03, memdata_i=0x80FF_0000 -> rddata_o=0xFFFF_FF80. LBU, same inputs -> 0x0000_0080. LH, offset 2, same memdata -> 0xFFFF_80FF.
- Store (opcode 0100011) and ADDI x0 with RETIRE_ALL=1 -> rdvalid_o=0 for both, instret_o advances by 2. Repeat with RETIRE_ALL=0 -> instret_o unchanged.
- Back-pressure: issue A, B, C back-to-back, wb_ready_i=0 for 3 cycles -> A held, B in skid, ready_o=0 and C waits. Release -> A, B, C retire in order, one per cycle, no duplicates.
- Counter wrap with CNT_W=4: 16 retires -> instret_o returns to 0. Reset asserted with the skid full -> both entries dropped and no spurious rdvalid_o.
